// File: rtl/nonce_collector.sv
// Nonce collector: qualifies miner hits after a post-restart holdoff and
// buffers them in a first-word-fall-through FIFO with a registered head.
module nonce_collector #(
  parameter int DEPTH   = 16,
  parameter int HOLDOFF = 300,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    work_new,
  input  logic                    nonce_found,
  input  logic [31:0]             nonce_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [31:0]             res_nonce,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNT_W-1:0]        found_count,
  output logic                    holdoff_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int HW = $clog2(HOLDOFF + 2);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [HW-1:0] hold_cnt_r;

  logic [PW-1:0] wr_next_s;
  logic [PW-1:0] rd_next_s;
  logic [PW-1:0] lvl_next_s;
  logic [HW-1:0] hold_next_s;
  logic [31:0]   head_next_s;
  logic          full_s;
  logic          qual_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;

  // Next-state computation for pointers, head register and holdoff counter.
  always_comb begin
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    qual_s    = nonce_found && (hold_cnt_r == {HW{1'b0}}) && !work_new && !reset;
    pop_s     = res_valid && res_ready && !work_new && !reset;
    push_s    = qual_s && (!full_s || pop_s);
    drop_s    = qual_s && full_s && !pop_s;
    wr_next_s = wr_ptr_r + {{(PW-1){1'b0}}, push_s};
    rd_next_s = rd_ptr_r + {{(PW-1){1'b0}}, pop_s};
    lvl_next_s = wr_next_s - rd_next_s;
    // The entry being written this cycle only becomes the head if the FIFO drains to it.
    if (push_s && (wr_ptr_r[AW-1:0] == rd_next_s[AW-1:0])) begin
      head_next_s = nonce_out;
    end else begin
      head_next_s = mem[rd_next_s[AW-1:0]];
    end
    if (hold_cnt_r != {HW{1'b0}}) begin
      hold_next_s = hold_cnt_r - {{(HW-1){1'b0}}, 1'b1};
    end else begin
      hold_next_s = hold_cnt_r;
    end
  end

  // Storage array; push is already suppressed during reset and work_new.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r[AW-1:0]] <= nonce_out;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset || work_new) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      res_valid    <= 1'b0;
      res_nonce    <= 32'h0000_0000;
      level        <= {PW{1'b0}};
      overflow     <= 1'b0;
      found_count  <= {CNT_W{1'b0}};
      hold_cnt_r   <= HW'(HOLDOFF);
      holdoff_busy <= (HW'(HOLDOFF) != {HW{1'b0}});
    end else begin
      wr_ptr_r     <= wr_next_s;
      rd_ptr_r     <= rd_next_s;
      res_valid    <= (wr_next_s != rd_next_s);
      level        <= lvl_next_s;
      hold_cnt_r   <= hold_next_s;
      holdoff_busy <= (hold_next_s != {HW{1'b0}});
      if (wr_next_s != rd_next_s) begin
        res_nonce <= head_next_s;
      end
      if (drop_s) begin
        overflow <= 1'b1;
      end
      if (push_s && (found_count != {CNT_W{1'b1}})) begin
        found_count <= found_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_nonce_collector.sv
// Randomized scoreboard bench for nonce_collector against a queue-level model.
module tb_nonce_collector;

  localparam int DEPTH   = 16;
  localparam int HOLDOFF = 300;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, work_new = 1'b0, nonce_found = 1'b0, res_ready = 1'b0;
  logic [31:0] nonce_out = 32'h0;
  logic        res_valid, overflow, holdoff_busy;
  logic [31:0] res_nonce;
  logic [4:0]  level;
  logic [31:0] found_count;

  logic        reset2 = 1'b1, work_new2 = 1'b0, nonce_found2 = 1'b0, res_ready2 = 1'b0;
  logic [31:0] nonce_out2 = 32'h0;
  logic        res_valid2, overflow2, holdoff_busy2;
  logic [31:0] res_nonce2;
  logic [4:0]  level2;
  logic [3:0]  found_count2;
  bit          done2 = 1'b0;

  nonce_collector #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .work_new(work_new), .nonce_found(nonce_found),
    .nonce_out(nonce_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .level(level), .overflow(overflow),
    .found_count(found_count), .holdoff_busy(holdoff_busy));

  nonce_collector #(.DEPTH(16), .HOLDOFF(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .work_new(work_new2), .nonce_found(nonce_found2),
    .nonce_out(nonce_out2), .res_valid(res_valid2), .res_ready(res_ready2),
    .res_nonce(res_nonce2), .level(level2), .overflow(overflow2),
    .found_count(found_count2), .holdoff_busy(holdoff_busy2));

  int vectors = 0;
  int miscompares = 0;

  int          m_level = 0;
  bit          m_ovf = 1'b0;
  longint      m_cnt = 0;
  int          m_hold = HOLDOFF;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then check state after the edge.
  task automatic step(input bit rst, input bit wn, input bit nf, input logic [31:0] nv,
                      input bit rdy);
    bit pop_m;
    bit qual_m;
    reset = rst; work_new = wn; nonce_found = nf; nonce_out = nv; res_ready = rdy;
    pop_m = (m_level > 0) && rdy && !wn && !rst;
    if (rst || wn) begin
      m_level = 0; m_ovf = 1'b0; m_cnt = 0; m_hold = HOLDOFF;
      exp_q.delete();
    end else begin
      qual_m = nf && (m_hold == 0);
      if (m_hold > 0) m_hold--;
      if (pop_m) m_level--;
      if (qual_m) begin
        if (m_level < DEPTH) begin
          m_level++;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          exp_q.push_back(nv);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    chk("level", 64'(level), 64'(m_level));
    chk("res_valid", 64'(res_valid), 64'(m_level != 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("found_count", 64'(found_count), 64'(m_cnt));
    chk("holdoff_busy", 64'(holdoff_busy), 64'(m_hold != 0));
  endtask

  // Monitor: every accepted head must match the oldest expected nonce.
  always @(negedge clk) begin
    if (reset === 1'b0 && work_new === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 64'(res_nonce), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("pop_order", 64'(res_nonce), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step2(input bit rst, input bit nf, input logic [31:0] nv, input bit rdy);
    reset2 = rst; nonce_found2 = nf; nonce_out2 = nv; res_ready2 = rdy;
    @(posedge clk); #1;
  endtask

  // Saturation scenario on a narrow-counter instance.
  initial begin
    step2(1'b1, 1'b0, 32'h0, 1'b0);
    step2(1'b0, 1'b0, 32'h0, 1'b0);
    step2(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) step2(1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0);
    chk("t6_count15", 64'(found_count2), 64'hF);
    chk("t6_level15", 64'(level2), 64'd15);
    step2(1'b0, 1'b1, 32'hB0, 1'b1);
    step2(1'b0, 1'b1, 32'hB1, 1'b1);
    step2(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t6_saturate", 64'(found_count2), 64'hF);
    chk("t6_level", 64'(level2), 64'd15);
    chk("t6_head", 64'(res_nonce2), 64'hA2);
    done2 = 1'b1;
  end

  initial begin
    bit rdy_hi;
    // Test 1: reset, then hits throughout the holdoff window.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_res_nonce", 64'(res_nonce), 64'h0);
    for (int i = 0; i < HOLDOFF; i++) begin
      step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
      if (i == HOLDOFF - 2) chk("t1_busy_299", 64'(holdoff_busy), 64'd1);
    end
    chk("t1_busy_300", 64'(holdoff_busy), 64'd0);
    chk("t1_level", 64'(level), 64'd0);

    // Test 2: single hit, next cycle visible at head.
    step(1'b0, 1'b0, 1'b1, 32'h0000_1234, 1'b0);
    chk("t2_nonce", 64'(res_nonce), 64'h1234);
    chk("t2_count", 64'(found_count), 64'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Test 3: 17 hits into a 16-deep FIFO, then drain.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
    chk("t3_level", 64'(level), 64'd16);
    chk("t3_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Test 4: push while full with a simultaneous pop.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < HOLDOFF; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 32'h200 + 32'(i), 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
    chk("t4_level", 64'(level), 64'd16);
    chk("t4_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Test 5: work_new with a hit and a pop in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h400 + 32'(i), 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("t5_level", 64'(level), 64'd0);
    chk("t5_count", 64'(found_count), 64'd0);
    for (int i = 0; i < HOLDOFF; i++)
      step(1'b0, 1'b0, 1'($urandom % 2), $urandom, 1'($urandom % 2));
    chk("t5_ignored", 64'(level), 64'd0);

    // Randomized phases alternating between slow and fast consumers.
    for (int i = 0; i < 3000; i++) begin
      rdy_hi = ((i / 250) % 2) == 1;
      step(($urandom % 2000) == 0, ($urandom % 1200) == 0, ($urandom % 3) != 0,
           $urandom, rdy_hi ? (($urandom % 4) != 0) : (($urandom % 4) == 0));
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    chk("dut2_done", 64'(done2), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
